mux4_rr_arbiter: RTL and testbench

Round-robin controller that shares a single 4-to-1 multiplexer datapath among four requesters. It grants one requester at a time, drives the mux select pair S1/S0 and a one-hot grant vector, and forwards the granted requester's data downstream under a valid/ready handshake. Each grant is held for a burst of at most MAX_HOLD accepted transfers, then passed on. The block sits in front of the existing 4:1 multiplexer and owns its select lines.

---
 rtl/mux4_rr_arbiter.sv | 118 +++++++++++
 tb/tb_mux4_rr_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux datapath among four requesters.
// Grants are held for up to MAX_HOLD accepted transfers, with one IDLE cycle between grants.
module mux4_rr_arbiter #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [WIDTH-1:0] C,
  input  logic [WIDTH-1:0] D,
  output logic [3:0]       gnt,
  output logic             S1,
  output logic             S0,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Out
);

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(MAX_HOLD - 1);

  state_t     state, state_nxt;
  logic [3:0] gnt_nxt;
  logic [1:0] sel, sel_nxt;
  logic [1:0] ptr, ptr_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic       found;
  logic [1:0] winner;
  logic       xfer;
  logic       last;

  assign {S1, S0}  = sel;
  assign out_valid = (state == GRANT) && req[sel];
  assign xfer      = out_valid && out_ready;
  assign last      = (cnt == CNT_LAST);

  always_comb begin
    case (sel)
      2'd0:    Out = A;
      2'd1:    Out = B;
      2'd2:    Out = C;
      default: Out = D;
    endcase
  end

  // First set request bit, scanning upward from ptr with wrap-around.
  always_comb begin : search
    logic [1:0] idx;
    found  = 1'b0;
    winner = ptr;
    idx    = ptr;
    for (int unsigned k = 0; k < 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && req[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    ptr_nxt   = ptr;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_nxt = GRANT;
          gnt_nxt   = 4'b0001 << winner;
          sel_nxt   = winner;
          cnt_nxt   = '0;
        end
      end
      GRANT: begin
        // Owner dropping req releases immediately; a stall never releases.
        if (!req[sel] || (xfer && last)) begin
          state_nxt = IDLE;
          gnt_nxt   = '0;
          ptr_nxt   = sel + 2'd1;
          cnt_nxt   = '0;
        end else if (xfer) begin
          cnt_nxt = cnt + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = '0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      sel   <= sel_nxt;
      ptr   <= ptr_nxt;
      cnt   <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: reset, bursts, round robin, early release,
// backpressure, reset mid-burst and idle behaviour with hand-computed expectations.
module tb_mux4_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [7:0] A, B, C, D;
  logic [3:0] gnt;
  logic       S1, S0;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] Out;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;
  int unsigned xfers;
  logic [7:0] dat [4];

  mux4_rr_arbiter #(.WIDTH(8), .MAX_HOLD(4)) dut (
    .clk(clk), .rst(rst), .req(req),
    .A(A), .B(B), .C(C), .D(D),
    .gnt(gnt), .S1(S1), .S0(S0),
    .out_valid(out_valid), .out_ready(out_ready), .Out(Out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compares grant, select, valid and, when valid, the forwarded data.
  task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic v, input logic [7:0] o);
    chk({tag, ".gnt"}, 32'(gnt), 32'(g));
    chk({tag, ".sel"}, 32'({S1, S0}), 32'(s));
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    if (v) chk({tag, ".out"}, 32'(Out), 32'(o));
    if (out_valid && out_ready) xfers++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0000;
    out_ready = 1'b1;
    tick();
    tick();
    chk_all("reset", 4'b0000, 2'd0, 1'b0, 8'h00);
    chk("reset.out_is_A", 32'(Out), 32'(8'hA1));
    rst = 1'b0;
  endtask

  initial begin
    A = 8'hA1; B = 8'hB2; C = 8'h3C; D = 8'hD4;
    dat[0] = 8'hA1; dat[1] = 8'hB2; dat[2] = 8'h3C; dat[3] = 8'hD4;
    rst = 1'b1; req = '0; out_ready = 1'b1;

    // Single requester C: 4 transfers, one idle cycle, re-grant to C.
    do_reset();
    req = 4'b0100;
    xfers = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_all("single.burst", 4'b0100, 2'd2, 1'b1, 8'h3C);
    end
    chk("single.xfers", 32'(xfers), 32'd4);
    tick();
    chk_all("single.idle", 4'b0000, 2'd2, 1'b0, 8'h00);
    tick();
    chk_all("single.regrant", 4'b0100, 2'd2, 1'b1, 8'h3C);
    req = 4'b0000;

    // Round robin with all requesting: A, B, C, D, A.
    do_reset();
    req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      logic [1:0] o;
      o = 2'(b % 4);
      xfers = 0;
      for (int i = 0; i < 4; i++) begin
        tick();
        chk_all("rr.burst", 4'b0001 << o, o, 1'b1, dat[o]);
      end
      chk("rr.xfers", 32'(xfers), 32'd4);
      tick();
      chk_all("rr.idle", 4'b0000, o, 1'b0, 8'h00);
    end
    req = 4'b0000;

    // Early release of B after 2 transfers; ptr moves to C.
    do_reset();
    req = 4'b0010;
    tick();
    chk_all("early.x1", 4'b0010, 2'd1, 1'b1, 8'hB2);
    tick();
    chk_all("early.x2", 4'b0010, 2'd1, 1'b1, 8'hB2);
    req = 4'b0000;
    #1;
    chk_all("early.drop", 4'b0010, 2'd1, 1'b0, 8'h00);
    tick();
    chk_all("early.idle", 4'b0000, 2'd1, 1'b0, 8'h00);
    req = 4'b0101;
    tick();
    chk_all("early.c_wins", 4'b0100, 2'd2, 1'b1, 8'h3C);
    req = 4'b0000;

    // Backpressure on A: 5 stall cycles, then exactly 4 transfers.
    do_reset();
    out_ready = 1'b0;
    req = 4'b0001;
    xfers = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_all("bp.stall", 4'b0001, 2'd0, 1'b1, 8'hA1);
    end
    out_ready = 1'b1;
    #1;
    chk_all("bp.x1", 4'b0001, 2'd0, 1'b1, 8'hA1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_all("bp.xn", 4'b0001, 2'd0, 1'b1, 8'hA1);
    end
    chk("bp.xfers", 32'(xfers), 32'd4);
    tick();
    chk_all("bp.idle", 4'b0000, 2'd0, 1'b0, 8'h00);
    req = 4'b0000;

    // Reset in the middle of a D burst, then A wins from ptr = 0.
    do_reset();
    req = 4'b1000;
    tick();
    chk_all("rstmid.x1", 4'b1000, 2'd3, 1'b1, 8'hD4);
    tick();
    chk_all("rstmid.x2", 4'b1000, 2'd3, 1'b1, 8'hD4);
    rst = 1'b1;
    out_ready = 1'b0;
    tick();
    chk_all("rstmid.after", 4'b0000, 2'd0, 1'b0, 8'h00);
    rst = 1'b0;
    out_ready = 1'b1;
    req = 4'b1001;
    tick();
    chk_all("rstmid.a_wins", 4'b0001, 2'd0, 1'b1, 8'hA1);
    req = 4'b0000;

    // No requests for 10 cycles.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_all("noreq", 4'b0000, 2'd0, 1'b0, 8'h00);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
